// File: rtl/spi_slave_apb_mem.sv
// APB completer: word-addressed flop memory with programmable wait states and
// saturating access counters. Define APB_MEM_ERR_EN to flag out-of-range addresses.
module spi_slave_apb_mem #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      psel,
    input  logic                      penable,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic                      pwrite,
    input  logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic [APB_DATA_WIDTH-1:0] prdata,
    output logic                      pready,
    output logic                      pslverr,
    input  logic [3:0]                wait_cfg,
    output logic [15:0]               wr_count,
    output logic [15:0]               rd_count
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [3:0]                wait_cnt_q, wait_cnt_d;
    logic [15:0]               wr_count_q, wr_count_d;
    logic [15:0]               rd_count_q, rd_count_d;
    logic [APB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             done;
    logic             wr_en;

    assign idx = paddr[IDX_W-1:0];

`ifdef APB_MEM_ERR_EN
    assign addr_err = (paddr >> IDX_W) != '0;
`else
    // High address bits deliberately alias onto the memory.
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^paddr[APB_ADDR_WIDTH-1:IDX_W];
    assign addr_err        = 1'b0;
`endif

    always_comb begin
        pready  = (state_q == ST_ACCESS) && psel && penable && (wait_cnt_q == '0);
        pslverr = pready && addr_err;
        done    = pready && !pslverr;
        wr_en   = done && pwrite;
        prdata  = (done && !pwrite) ? mem_q[idx] : '0;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    wait_cnt_d = wait_cfg;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (penable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (done && pwrite && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (done && !pwrite && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= pwdata;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_spi_slave_apb_mem.sv
// Self-checking bench for spi_slave_apb_mem: expected responses are queued when a
// transfer is issued and compared when pready is observed.
module tb_spi_slave_apb_mem;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } rec_t;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  wait_cfg;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    logic [31:0] model_mem [256];
    rec_t exp_q[$];
    rec_t obs_q[$];

    always #5 pclk = ~pclk;

    spi_slave_apb_mem #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .MEM_DEPTH     (256)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .wait_cfg(wait_cfg),
        .wr_count(wr_count),
        .rd_count(rd_count)
    );

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        exp_wr = 0;
        exp_rd = 0;
    endtask

    // Issues one transfer; the setup lands in the cycle after the caller's last
    // completion, so consecutive calls are back-to-back with no idle cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] wc, input logic [3:0] wc_mid, input string tag);
        rec_t e;
        rec_t o;
        logic err;
        err = 1'b0;
`ifdef APB_MEM_ERR_EN
        err = (a >= 32'd256);
`endif
        e.lat   = int'(wc) + 1;
        e.err   = err;
        e.rdata = (!w && !err) ? model_mem[a[7:0]] : 32'h0;
        e.tag   = tag;
        exp_q.push_back(e);
        if (!err) begin
            if (w) begin
                model_mem[a[7:0]] = d;
                if (exp_wr < 65535) exp_wr++;
            end else if (exp_rd < 65535) begin
                exp_rd++;
            end
        end
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; wait_cfg = wc;
        @(posedge pclk); #1;
        penable = 1'b1; wait_cfg = wc_mid;
        o.lat = -1; o.rdata = 'x; o.err = 1'bx; o.tag = tag;
        for (int c = 1; c <= 40; c++) begin
            @(negedge pclk);
            if (pready === 1'b1) begin
                o.lat = c; o.rdata = prdata; o.err = pslverr;
                break;
            end
        end
        obs_q.push_back(o);
    endtask

    task automatic bus_idle();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        rec_t e;
        rec_t o;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pwdata = '0; wait_cfg = '0;
        model_reset();
        repeat (3) @(negedge pclk);
        n_cmp++;
        if ({pready, pslverr, prdata, wr_count, rd_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h wc=%0d rc=%0d, required all 0",
                     pready, pslverr, prdata, wr_count, rd_count);
        end
        presetn = 1'b1;
        xfer(1'b0, 32'd5, 32'h0, 4'd0, 4'd0, "rd5_after_reset");
        bus_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
        n_cmp++;
        if (rd_count !== 16'd1 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got wr=%0d rd=%0d, required wr=0 rd=1", wr_count, rd_count);
        end
    endtask

    task automatic test_write_read();
        rec_t e;
        rec_t o;
        xfer(1'b1, 32'd3, 32'hDEADBEEF, 4'd0, 4'd0, "wr3");
        xfer(1'b0, 32'd3, 32'h0, 4'd0, 4'd0, "rd3");
        bus_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
        n_cmp++;
        if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
            n_fail++;
            $display("FAIL wr_rd_counts: got wr=%0d rd=%0d, required wr=%0d rd=%0d",
                     wr_count, rd_count, exp_wr, exp_rd);
        end
    endtask

    task automatic test_wait_states();
        rec_t e;
        rec_t o;
        xfer(1'b0, 32'd3, 32'h0, 4'd3, 4'd3, "wait3_held");
        xfer(1'b0, 32'd3, 32'h0, 4'd3, 4'd0, "wait3_cfg_changed");
        xfer(1'b0, 32'd3, 32'h0, 4'd0, 4'd0, "wait0_next");
        xfer(1'b1, 32'd9, 32'h0BADF00D, 4'd15, 4'd15, "wait15_wr9");
        xfer(1'b0, 32'd9, 32'h0, 4'd7, 4'd2, "wait7_rd9");
        bus_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e;
        rec_t o;
        int wr0;
        int rd0;
        wr0 = exp_wr;
        rd0 = exp_rd;
        for (int i = 0; i < 4; i++) xfer(1'b1, 32'h10 + i, 32'hA0 + i, 4'd1, 4'd1, "burst_wr");
        for (int i = 0; i < 4; i++) xfer(1'b0, 32'h10 + i, 32'h0, 4'd0, 4'd0, "burst_rd");
        bus_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
        n_cmp++;
        if (wr_count !== 16'(wr0 + 4) || rd_count !== 16'(rd0 + 4)) begin
            n_fail++;
            $display("FAIL burst_counts: got wr=%0d rd=%0d, required wr=%0d rd=%0d",
                     wr_count, rd_count, wr0 + 4, rd0 + 4);
        end
    endtask

    task automatic test_enable_without_setup();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; paddr = 32'd3; pwrite = 1'b1; pwdata = 32'h11111111;
        wait_cfg = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            n_cmp++;
            if (pready !== 1'b0) begin
                n_fail++;
                $display("FAIL no_setup_pready: got %b, required 0", pready);
            end
        end
        bus_idle();
        xfer(1'b0, 32'd3, 32'h0, 4'd0, 4'd0, "no_setup_mem_intact");
        bus_idle();
        while (exp_q.size() > 0) begin
            rec_t e;
            rec_t o;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
        n_cmp++;
        if (wr_count !== 16'(exp_wr)) begin
            n_fail++;
            $display("FAIL no_setup_wr_count: got %0d, required %0d", wr_count, exp_wr);
        end
    endtask

    task automatic test_addr_range();
        rec_t e;
        rec_t o;
        xfer(1'b1, 32'd256, 32'h55, 4'd0, 4'd0, "wr256");
        xfer(1'b0, 32'd0, 32'h0, 4'd0, 4'd0, "rd0_after_wr256");
        xfer(1'b0, 32'd256, 32'h0, 4'd2, 4'd2, "rd256");
        bus_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
        n_cmp++;
        if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
            n_fail++;
            $display("FAIL range_counts: got wr=%0d rd=%0d, required wr=%0d rd=%0d",
                     wr_count, rd_count, exp_wr, exp_rd);
        end
    endtask

    task automatic test_reset_mid_transfer();
        xfer(1'b1, 32'd7, 32'h77, 4'd0, 4'd0, "pre_wr7");
        void'(exp_q.pop_front());
        void'(obs_q.pop_front());
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'd7; pwrite = 1'b1; pwdata = 32'h1234;
        wait_cfg = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(negedge pclk);
        n_cmp++;
        if (pready !== 1'b0 || wr_count !== 16'd0 || rd_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b wr=%0d rd=%0d, required 0 0 0",
                     pready, wr_count, rd_count);
        end
        model_reset();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        xfer(1'b0, 32'd7, 32'h0, 4'd0, 4'd0, "rd7_after_reset");
        bus_idle();
        while (exp_q.size() > 0) begin
            rec_t e;
            rec_t o;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
    endtask

    task automatic test_psel_abort();
        int wr0;
        wr0 = exp_wr;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'd7; pwrite = 1'b1; pwdata = 32'h1234;
        wait_cfg = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            n_cmp++;
            if (pready !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_pready: got %b, required 0", pready);
            end
        end
        n_cmp++;
        if (wr_count !== 16'(wr0)) begin
            n_fail++;
            $display("FAIL abort_wr_count: got %0d, required %0d", wr_count, wr0);
        end
        xfer(1'b0, 32'd7, 32'h0, 4'd0, 4'd0, "rd7_after_abort");
        bus_idle();
        while (exp_q.size() > 0) begin
            rec_t e;
            rec_t o;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no response, required lat=%0d", e.tag, e.lat);
            end else begin
                o = obs_q.pop_front();
                if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got lat=%0d rd=%h err=%b, required lat=%0d rd=%h err=%b",
                             e.tag, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_back_to_back();
        test_enable_without_setup();
        test_addr_range();
        test_reset_mid_transfer();
        test_psel_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
